fetch_controller: RTL and testbench

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/fetch_controller_if.sv | 21 ++
 rtl/fetch_controller.sv | 130 +++++++++++++
 tb/tb_fetch_controller.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_controller_if.sv
// Loader and instruction-memory signals shared by the fetch controller and its environment.
interface fetch_controller_if;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic [31:0] imem_addr;
  logic        imem_we;
  logic [31:0] imem_wdata;
  logic [31:0] imem_rdata;

  modport master (
    input  load_valid, load_data, load_last, imem_rdata,
    output load_ready, imem_addr, imem_we, imem_wdata
  );

  modport slave (
    output load_valid, load_data, load_last, imem_rdata,
    input  load_ready, imem_addr, imem_we, imem_wdata
  );
endinterface

// File: rtl/fetch_controller.sv
// Loads an image into instruction memory, then streams pc/instr with 1-cycle fetch latency.
// Stall holds the current fetch; a redirect inserts one bubble; bad fetch addresses halt until reset.
module fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               halt,
  fetch_controller_if.master bus,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic [31:0]        pc,
  output logic [31:0]        instr,
  output logic               instr_valid,
  output logic               fault,
  output logic [1:0]         state
);
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, HALT = 2'd3} state_t;

  localparam logic [31:0] LAST_IDX = 32'(DEPTH - 1);
  localparam logic [31:0] DEPTH_W  = 32'(DEPTH);

  state_t      cur_state, nxt_state;
  logic [31:0] load_cnt;
  logic [31:0] fetch_addr;
  logic        accept;
  logic        load_done;
  logic        bad_addr;

  // Reset masks acceptance so an aborted load never writes on the reset cycle.
  assign accept    = (cur_state == LOAD) && bus.load_valid && !reset;
  assign load_done = accept && (bus.load_last || (load_cnt == LAST_IDX));
  assign bad_addr  = ({2'b00, fetch_addr[31:2]} >= DEPTH_W) || (fetch_addr[1:0] != 2'b00);
  assign state     = cur_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      IDLE: begin
        if (bus.load_valid) begin
          nxt_state = LOAD;
        end else if (start) begin
          nxt_state = RUN;
        end
      end
      LOAD: begin
        if (load_done) begin
          nxt_state = IDLE;
        end
      end
      RUN: begin
        if (halt) begin
          nxt_state = IDLE;
        end else if (!redirect && bad_addr) begin
          nxt_state = HALT;
        end
      end
      default: nxt_state = HALT;
    endcase
  end

  always_comb begin
    bus.load_ready = 1'b0;
    bus.imem_we    = 1'b0;
    bus.imem_wdata = 32'h0;
    bus.imem_addr  = {2'b00, fetch_addr[31:2]};
    if (cur_state == LOAD) begin
      bus.load_ready = !reset;
      bus.imem_we    = accept;
      bus.imem_wdata = accept ? bus.load_data : 32'h0;
      bus.imem_addr  = load_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
      load_cnt    <= 32'h0;
      fetch_addr  <= RESET_PC;
    end else begin
      case (cur_state)
        IDLE: begin
          instr_valid <= 1'b0;
          if (bus.load_valid) begin
            load_cnt <= 32'h0;
          end else if (start) begin
            fetch_addr <= RESET_PC;
          end
        end
        LOAD: begin
          if (accept) begin
            load_cnt <= load_cnt + 32'd1;
          end
        end
        RUN: begin
          // Priority: halt, redirect, bad address, stall, normal fetch.
          if (halt) begin
            instr_valid <= 1'b0;
          end else if (redirect) begin
            fetch_addr  <= redirect_pc;
            instr_valid <= 1'b0;
          end else if (bad_addr) begin
            fault       <= 1'b1;
            instr_valid <= 1'b0;
          end else if (!stall) begin
            instr       <= bus.imem_rdata;
            pc          <= fetch_addr;
            instr_valid <= 1'b1;
            fetch_addr  <= fetch_addr + 32'd4;
          end
        end
        default: instr_valid <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: expected writes and fetches are queued as stimulus is driven.
module tb_fetch_controller;
  localparam logic [1:0] S_IDLE = 2'd0, S_LOAD = 2'd1, S_RUN = 2'd2, S_HALT = 2'd3;

  typedef struct {logic [31:0] addr; logic [31:0] data;} wr_t;
  typedef struct {logic [31:0] pc; logic [31:0] instr;} fetch_t;

  logic        clk = 1'b0;
  logic        reset, start, halt, stall, redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc, instr;
  logic        instr_valid, fault;
  logic [1:0]  state;

  fetch_controller_if bus();

  fetch_controller #(.RESET_PC(32'h0000_0000), .DEPTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt), .bus(bus),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .pc(pc), .instr(instr), .instr_valid(instr_valid), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:31];
  always @(posedge clk) begin
    if (bus.imem_we && bus.imem_addr < 32) mem[bus.imem_addr[4:0]] <= bus.imem_wdata;
  end
  assign bus.imem_rdata = (bus.imem_addr < 32) ? mem[bus.imem_addr[4:0]] : 32'hDEAD_BEEF;

  int          vectors = 0;
  int          miscompares = 0;
  wr_t         wq[$];
  fetch_t      fq[$];
  fetch_t      last_exp;
  logic [31:0] exp_mem [0:31];
  logic [31:0] model_fa;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [31:0] base, input int n, input int last_idx,
                         input int rst_at, input int exp_writes);
    int  writes = 0;
    bit  done = 1'b0;
    bit  exp_we;
    wr_t w;
    wq.delete();
    bus.load_valid = 1'b1; bus.load_data = base; bus.load_last = (last_idx == 0);
    tick();
    for (int i = 0; i < n; i++) begin
      bus.load_data = base + 32'(i); bus.load_last = (i == last_idx);
      if (i == rst_at) begin
        reset = 1'b1;
        #1;
        vectors++; if (bus.imem_we !== 1'b0) begin miscompares++; $display("FAIL rst_no_write: imem_we=%b want 0", bus.imem_we); end
        tick();
        break;
      end
      #1;
      if (state != S_LOAD) break;
      exp_we = !done;
      if (!done) begin
        wq.push_back('{addr: 32'(i), data: base + 32'(i)});
        exp_mem[i] = base + 32'(i);
        done = (i == last_idx) || (i == 31);
      end
      vectors++; if (bus.imem_we !== exp_we) begin miscompares++; $display("FAIL load_we word %0d: imem_we=%b want %b", i, bus.imem_we, exp_we); end
      if (bus.imem_we === 1'b1 && wq.size() > 0) begin
        w = wq.pop_front();
        writes++;
        vectors++; if (bus.imem_addr !== w.addr) begin miscompares++; $display("FAIL load_addr: got %0d want %0d", bus.imem_addr, w.addr); end
        vectors++; if (bus.imem_wdata !== w.data) begin miscompares++; $display("FAIL load_data: got %h want %h", bus.imem_wdata, w.data); end
      end
      tick();
    end
    if (rst_at < 0) begin
      vectors++; if (state !== S_IDLE) begin miscompares++; $display("FAIL load_end_state: got %0d want %0d", state, S_IDLE); end
      vectors++; if (bus.load_ready !== 1'b0) begin miscompares++; $display("FAIL load_end_ready: got %b want 0", bus.load_ready); end
      vectors++; if (bus.imem_we !== 1'b0) begin miscompares++; $display("FAIL load_end_we: got %b want 0", bus.imem_we); end
    end
    bus.load_valid = 1'b0; bus.load_last = 1'b0;
    vectors++; if (writes != exp_writes) begin miscompares++; $display("FAIL load_count: got %0d writes want %0d", writes, exp_writes); end
    vectors++; if (wq.size() != 0) begin miscompares++; $display("FAIL load_pending: %0d expected writes never seen", wq.size()); end
  endtask

  task automatic fetch_step();
    fetch_t e;
    fq.push_back('{pc: model_fa, instr: exp_mem[model_fa[6:2]]});
    model_fa = model_fa + 32'd4;
    tick();
    vectors++; if (instr_valid !== 1'b1) begin miscompares++; $display("FAIL fetch_valid: got %b want 1", instr_valid); end
    if (fq.size() > 0) begin
      e = fq.pop_front();
      last_exp = e;
      vectors++; if (pc !== e.pc) begin miscompares++; $display("FAIL fetch_pc: got %h want %h", pc, e.pc); end
      vectors++; if (instr !== e.instr) begin miscompares++; $display("FAIL fetch_instr: got %h want %h", instr, e.instr); end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; halt = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    bus.load_valid = 1'b0; bus.load_data = 32'h0; bus.load_last = 1'b0;
    tick(); tick();
    vectors++; if (state !== S_IDLE) begin miscompares++; $display("FAIL reset_state: got %0d want %0d", state, S_IDLE); end
    vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h want 0", pc); end
    vectors++; if (instr !== 32'h0) begin miscompares++; $display("FAIL reset_instr: got %h want 0", instr); end
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL reset_fault: got %b want 0", fault); end
    vectors++; if (bus.load_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b want 0", bus.load_ready); end
    vectors++; if (bus.imem_we !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %b want 0", bus.imem_we); end
    reset = 1'b0;
  endtask

  task automatic test_load();
    do_load(32'hAAAA_0001, 5, 2, -1, 3);
  endtask

  task automatic test_load_overflow();
    do_load(32'h0, 40, -1, -1, 32);
  endtask

  task automatic test_fetch();
    start = 1'b1; tick(); start = 1'b0;
    vectors++; if (state !== S_RUN) begin miscompares++; $display("FAIL run_entry_state: got %0d want %0d", state, S_RUN); end
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL run_entry_valid: got %b want 0", instr_valid); end
    model_fa = 32'h0;
    repeat (3) fetch_step();
  endtask

  task automatic test_stall_redirect();
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      vectors++; if (pc !== last_exp.pc) begin miscompares++; $display("FAIL stall_pc: got %h want %h", pc, last_exp.pc); end
      vectors++; if (instr !== last_exp.instr) begin miscompares++; $display("FAIL stall_instr: got %h want %h", instr, last_exp.instr); end
      vectors++; if (instr_valid !== 1'b1) begin miscompares++; $display("FAIL stall_valid: got %b want 1", instr_valid); end
    end
    redirect = 1'b1; redirect_pc = 32'h14;
    tick();
    redirect = 1'b0; stall = 1'b0;
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL redirect_bubble: got %b want 0", instr_valid); end
    model_fa = 32'h14;
    repeat (2) fetch_step();
  endtask

  task automatic test_halt();
    halt = 1'b1; redirect = 1'b1; redirect_pc = 32'h40; stall = 1'b1;
    tick();
    halt = 1'b0; redirect = 1'b0; stall = 1'b0;
    vectors++; if (state !== S_IDLE) begin miscompares++; $display("FAIL halt_state: got %0d want %0d", state, S_IDLE); end
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL halt_valid: got %b want 0", instr_valid); end
    start = 1'b1; tick(); start = 1'b0;
    model_fa = 32'h0;
    fetch_step();
  endtask

  task automatic test_fault();
    redirect = 1'b1; redirect_pc = 32'h80;
    tick();
    redirect = 1'b0;
    tick();
    vectors++; if (state !== S_HALT) begin miscompares++; $display("FAIL range_state: got %0d want %0d", state, S_HALT); end
    vectors++; if (fault !== 1'b1) begin miscompares++; $display("FAIL range_fault: got %b want 1", fault); end
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL range_valid: got %b want 0", instr_valid); end
    vectors++; if (instr !== last_exp.instr) begin miscompares++; $display("FAIL range_instr_kept: got %h want %h", instr, last_exp.instr); end
    start = 1'b1; tick(); start = 1'b0;
    vectors++; if (state !== S_HALT) begin miscompares++; $display("FAIL halt_ignores_start: got %0d want %0d", state, S_HALT); end
    vectors++; if (fault !== 1'b1) begin miscompares++; $display("FAIL fault_sticky: got %b want 1", fault); end
    reset = 1'b1; tick(); reset = 1'b0;
    vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL fault_cleared: got %b want 0", fault); end
    start = 1'b1; tick(); start = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h6;
    tick();
    redirect = 1'b0;
    tick();
    vectors++; if (state !== S_HALT) begin miscompares++; $display("FAIL align_state: got %0d want %0d", state, S_HALT); end
    vectors++; if (fault !== 1'b1) begin miscompares++; $display("FAIL align_fault: got %b want 1", fault); end
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL align_valid: got %b want 0", instr_valid); end
  endtask

  task automatic test_reset_mid_load();
    reset = 1'b1; tick(); reset = 1'b0;
    do_load(32'hAAAA_0001, 40, -1, 5, 5);
    vectors++; if (state !== S_IDLE) begin miscompares++; $display("FAIL midload_state: got %0d want %0d", state, S_IDLE); end
    vectors++; if (bus.imem_we !== 1'b0) begin miscompares++; $display("FAIL midload_we: got %b want 0", bus.imem_we); end
    vectors++; if (bus.load_ready !== 1'b0) begin miscompares++; $display("FAIL midload_ready: got %b want 0", bus.load_ready); end
    vectors++; if (pc !== 32'h0 || instr !== 32'h0) begin miscompares++; $display("FAIL midload_pc_instr: got %h/%h want 0/0", pc, instr); end
    vectors++; if (instr_valid !== 1'b0 || fault !== 1'b0) begin miscompares++; $display("FAIL midload_flags: got valid=%b fault=%b want 0/0", instr_valid, fault); end
    reset = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    model_fa = 32'h0;
    repeat (2) fetch_step();
  endtask

  initial begin
    test_reset();
    test_load();
    test_load_overflow();
    test_fetch();
    test_stall_redirect();
    test_halt();
    test_fault();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
